// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared constants for the Maxnet processing unit: default
//               sizing, accumulator width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_N     = 4;
    localparam int c_W     = 16;
    localparam int c_FRAC  = 8;
    localparam int c_ACC_W = c_W + $clog2(c_N);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SUM    = 2'd1;
    localparam logic [1:0] c_UPDATE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/maxnet_update_lane.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_update_lane
// Description : Combinational single-neuron inhibition step:
//               max(0, a - (eps * (acc - a)) >> FRAC) plus a nonzero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_update_lane
    import maxnet_pkg::*;
#(
    parameter int W     = c_W,
    parameter int FRAC  = c_FRAC,
    parameter int ACC_W = c_ACC_W
) (
    input  logic [W-1:0]     i_a,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [W-1:0]     i_eps,
    output logic [W-1:0]     o_a_new,
    output logic             o_nonzero
);

    localparam int c_PROD_W = W + ACC_W;

    logic [ACC_W-1:0]    w_other;
    logic [c_PROD_W-1:0] w_prod_full;
    logic [c_PROD_W-1:0] w_prod;

    always_comb begin
        w_other     = i_acc - ACC_W'(i_a);
        w_prod_full = c_PROD_W'(i_eps) * c_PROD_W'(w_other);
        w_prod      = w_prod_full >> FRAC;
        // Full-width compare keeps large products from wrapping the subtraction.
        if (w_prod >= c_PROD_W'(i_a)) begin
            o_a_new = '0;
        end else begin
            o_a_new = i_a - w_prod[W-1:0];
        end
        o_nonzero = |o_a_new;
    end

endmodule
`default_nettype wire

// File: rtl/maxnet_plu.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_plu
// Description : Maxnet lateral-inhibition processing unit (one iteration per
//               start_plu). Optional winner_idx output: MAXNET_PLU_WINNER_IDX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_plu
    import maxnet_pkg::*;
#(
    parameter int N    = c_N,
    parameter int W    = c_W,
    parameter int FRAC = c_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_plu,
    input  logic [W-1:0]             eps,
    input  logic [N*W-1:0]           a_in,
    output logic [N*W-1:0]           a_out,
    output logic [$clog2(N+1)-1:0]   nonzero_cnt,
    output logic                     valid,
    output logic                     plu_done,
    output logic                     busy
`ifdef MAXNET_PLU_WINNER_IDX_EN
   ,output logic [$clog2(N)-1:0]     winner_idx
`endif
);

    localparam int c_IDX_W = $clog2(N);
    localparam int c_CNT_W = $clog2(N+1);
    localparam int c_ACCW  = W + $clog2(N);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(N-1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [N*W-1:0]     r_a;
    logic [N*W-1:0]     r_res;
    logic [N*W-1:0]     w_res_next;
    logic [W-1:0]       r_eps;
    logic [W-1:0]       w_a_sel;
    logic [W-1:0]       w_lane_new;
    logic               w_lane_nz;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_ACCW-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_last;

    always_comb begin
        w_a_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == c_IDX_W'(i)) w_a_sel = r_a[i*W +: W];
        end
    end

    maxnet_update_lane #(
        .W     (W),
        .FRAC  (FRAC),
        .ACC_W (c_ACCW)
    ) u_lane (
        .i_a       (w_a_sel),
        .i_acc     (r_acc),
        .i_eps     (r_eps),
        .o_a_new   (w_lane_new),
        .o_nonzero (w_lane_nz)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_res
            assign w_res_next[gi*W +: W] = (r_idx == c_IDX_W'(gi)) ? w_lane_new : r_res[gi*W +: W];
        end
    endgenerate

    assign w_cnt_next = r_cnt + c_CNT_W'(w_lane_nz);
    assign w_last     = (r_idx == c_LAST);
    assign busy       = (r_state != c_IDLE);

`ifdef MAXNET_PLU_WINNER_IDX_EN
    logic [c_IDX_W-1:0] w_winner;

    always_comb begin
        w_winner = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_res_next[i*W +: W] != '0) w_winner = c_IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (start_plu) w_state_next = c_SUM;
            c_SUM:    if (w_last)    w_state_next = c_UPDATE;
            c_UPDATE: if (w_last)    w_state_next = c_DONE;
            c_DONE:                  w_state_next = c_IDLE;
            default:                 w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_res       <= '0;
            r_eps       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            a_out       <= '0;
            nonzero_cnt <= '0;
            valid       <= 1'b0;
            plu_done    <= 1'b0;
`ifdef MAXNET_PLU_WINNER_IDX_EN
            winner_idx  <= '0;
`endif
        end else begin
            plu_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_plu) begin
                        r_a   <= a_in;
                        r_eps <= eps;
                        r_idx <= '0;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                c_SUM: begin
                    r_acc <= r_acc + c_ACCW'(w_a_sel);
                    r_idx <= w_last ? '0 : r_idx + c_IDX_W'(1);
                end
                c_UPDATE: begin
                    r_res <= w_res_next;
                    r_cnt <= w_cnt_next;
                    r_idx <= w_last ? '0 : r_idx + c_IDX_W'(1);
                    // Results load on the edge into DONE so they are visible alongside plu_done.
                    if (w_last) begin
                        a_out       <= w_res_next;
                        nonzero_cnt <= w_cnt_next;
                        valid       <= (w_cnt_next == c_CNT_W'(1));
                        plu_done    <= 1'b1;
`ifdef MAXNET_PLU_WINNER_IDX_EN
                        winner_idx  <= w_winner;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxnet_plu.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_plu
// Description : Self-checking bench for maxnet_plu with an expected-result
//               queue popped whenever plu_done fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_plu;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int CW   = $clog2(N+1);
    localparam int IW   = $clog2(N);

    typedef struct {
        logic [N*W-1:0] a;
        logic [CW-1:0]  cnt;
        logic           v;
        logic [IW-1:0]  win;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_plu;
    logic [W-1:0]   eps;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] a_out;
    logic [CW-1:0]  nonzero_cnt;
    logic           valid;
    logic           plu_done;
    logic           busy;
`ifdef MAXNET_PLU_WINNER_IDX_EN
    logic [IW-1:0]  winner_idx;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_x;

    always #5 clk = ~clk;

    maxnet_plu #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_plu   (start_plu),
        .eps         (eps),
        .a_in        (a_in),
        .a_out       (a_out),
        .nonzero_cnt (nonzero_cnt),
        .valid       (valid),
        .plu_done    (plu_done),
        .busy        (busy)
`ifdef MAXNET_PLU_WINNER_IDX_EN
       ,.winner_idx  (winner_idx)
`endif
    );

    function automatic exp_t model(input logic [N*W-1:0] a, input logic [W-1:0] e);
        exp_t   r;
        longint s;
        longint ai;
        longint prod;
        longint nv;
        bit     found;
        s = 0;
        found = 0;
        r.a = '0;
        r.cnt = '0;
        r.win = '0;
        for (int i = 0; i < N; i++) s += longint'(a[i*W +: W]);
        for (int i = 0; i < N; i++) begin
            ai   = longint'(a[i*W +: W]);
            prod = (longint'(e) * (s - ai)) >> FRAC;
            nv   = (prod >= ai) ? 0 : ai - prod;
            r.a[i*W +: W] = W'(nv);
            if (nv != 0) begin
                r.cnt = r.cnt + 1'b1;
                if (!found) begin
                    r.win = IW'(i);
                    found = 1;
                end
            end
        end
        r.v = (r.cnt == 1);
        return r;
    endfunction

    // Scoreboard: every plu_done pops one expected result.
    always @(posedge clk) begin
        #1;
        if (plu_done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: plu_done=1 required no pending result");
            end else begin
                mon_x = sb.pop_front();
                if (a_out !== mon_x.a) begin
                    n_fail++;
                    $display("FAIL sb_a_out: got %h required %h", a_out, mon_x.a);
                end
                n_checks++;
                if (nonzero_cnt !== mon_x.cnt) begin
                    n_fail++;
                    $display("FAIL sb_nonzero_cnt: got %0d required %0d", nonzero_cnt, mon_x.cnt);
                end
                n_checks++;
                if (valid !== mon_x.v) begin
                    n_fail++;
                    $display("FAIL sb_valid: got %b required %b", valid, mon_x.v);
                end
`ifdef MAXNET_PLU_WINNER_IDX_EN
                n_checks++;
                if (winner_idx !== mon_x.win) begin
                    n_fail++;
                    $display("FAIL sb_winner_idx: got %0d required %0d", winner_idx, mon_x.win);
                end
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [N*W-1:0] a, input logic [W-1:0] e);
        a_in      = a;
        eps       = e;
        start_plu = 1'b1;
        sb.push_back(model(a, e));
        tick();
        start_plu = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (plu_done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start_plu = 1'b0; eps = '0; a_in = '0;
        tick();
        tick();
        n_checks++;
        if (a_out !== '0 || nonzero_cnt !== '0 || valid !== 1'b0 || plu_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got a_out=%h cnt=%0d valid=%b done=%b busy=%b required all 0",
                     a_out, nonzero_cnt, valid, plu_done, busy);
        end
        start_plu = 1'b1; a_in = {4{16'd9}};
        tick();
        start_plu = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_during_rst: busy got %b required 0", busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors;
        logic [N*W-1:0] va [10];
        logic [W-1:0]   ve [10];
        exp_t           x;
        int             lat;
        va[0] = {16'd40, 16'd60, 16'd80, 16'd100};  ve[0] = 16'h0040;
        va[1] = {16'd0, 16'd50, 16'd0, 16'd0};      ve[1] = 16'h0040;
        va[2] = {4{16'hFFFF}};                      ve[2] = 16'h0100;
        va[3] = {4{16'd7}};                         ve[3] = 16'h0000;
        for (int k = 4; k < 10; k++) begin
            for (int i = 0; i < N; i++) va[k][i*W +: W] = W'($urandom_range(0, 400));
            ve[k] = W'($urandom_range(0, 512));
        end
        for (int k = 0; k < 10; k++) begin
            x = model(va[k], ve[k]);
            start_pass(va[k], ve[k]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_busy: got %b required 1", k, busy);
            end
            wait_done(lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d required 9", k, lat);
            end
            tick();
            n_checks++;
            if (plu_done !== 1'b0 || busy !== 1'b0 || a_out !== x.a) begin
                n_fail++;
                $display("FAIL vec%0d_hold: done=%b busy=%b a_out=%h required 0 0 %h",
                         k, plu_done, busy, a_out, x.a);
            end
        end
    endtask

    task automatic test_busy_ignore_back_to_back;
        int pulses;
        int lat;
        pulses = 0;
        start_pass({16'd10, 16'd20, 16'd30, 16'd200}, 16'h0080);
        for (int k = 1; k <= 8; k++) begin
            a_in      = {16'd500, 16'd1, 16'd2, 16'd3};
            eps       = 16'h0001;
            start_plu = 1'b1;
            if (plu_done === 1'b1) pulses++;
            tick();
        end
        start_plu = 1'b0;
        n_checks++;
        if (pulses !== 0 || plu_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_single_done: early pulses=%0d done@9=%b required 0 and 1", pulses, plu_done);
        end
        tick();
        start_pass({16'd0, 16'd120, 16'd30, 16'd10}, 16'h0040);
        wait_done(lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL back_to_back_latency: got %0d required 9", lat);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        int pulses;
        int lat;
        pulses = 0;
        start_pass({16'd1, 16'd2, 16'd3, 16'd90}, 16'h0020);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        n_checks++;
        if (a_out !== '0 || nonzero_cnt !== '0 || valid !== 1'b0 || busy !== 1'b0 || plu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: a_out=%h cnt=%0d valid=%b busy=%b done=%b required all 0",
                     a_out, nonzero_cnt, valid, busy, plu_done);
        end
        for (int k = 0; k < 15; k++) begin
            if (plu_done === 1'b1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses required 0", pulses);
        end
        start_pass({16'd5, 16'd300, 16'd5, 16'd5}, 16'h0040);
        wait_done(lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL abort_restart_latency: got %0d required 9", lat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_busy_ignore_back_to_back();
        test_reset_abort();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending results required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
